hs_arbiter_4ph: RTL and testbench

- Clocked arbiter that shares one 4-phase (return-to-zero) handshake resource between NUM_REQ asynchronous requesters.
- The shared resource is, for example, a Muller C-element pipeline stage.
- Each requester runs a full req/ack 4-phase cycle. The arbiter forwards exactly one requester at a time onto the resource req/ack pair.
- Sits between free-running async handshake sources and a single C-element-based datapath. Provides the clocked sequencing those primitives lack.

---
 rtl/hs_arbiter_4ph.sv | 152 +++++++++++++++
 tb/tb_hs_arbiter_4ph.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_arbiter_4ph.sv
// rtl/hs_arbiter_4ph.sv - round-robin arbiter sharing one 4-phase handshake resource
// between NUM_REQ asynchronous requesters; all async inputs pass through synchronizers.
module hs_arbiter_4ph #(
  parameter  int NUM_REQ        = 4,
  parameter  int SYNC_STAGES    = 2,
  parameter  int TIMEOUT_CYCLES = 1024,
  parameter  int CNT_W          = 16,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic               res_req,
  input  logic               res_ack,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_RTZ} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     req_sync_q [SYNC_STAGES];
  logic [NUM_REQ-1:0]     req_sync_d [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] res_ack_sync_q, res_ack_sync_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   res_req_q, res_req_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [NUM_REQ-1:0]     req_s;
  logic                   res_ack_s;
  logic [NUM_REQ-1:0]     eligible;
  logic                   win_found;
  logic [ID_W-1:0]        win_id;
  logic                   waiting;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      for (int k = 0; k < SYNC_STAGES; k++) req_sync_q[k] <= '0;
      res_ack_sync_q <= '0;
      ack_q          <= '0;
      res_req_q      <= 1'b0;
      grant_q        <= '0;
      ptr_q          <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_sync_q     <= req_sync_d;
      res_ack_sync_q <= res_ack_sync_d;
      ack_q          <= ack_d;
      res_req_q      <= res_req_d;
      grant_q        <= grant_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    req_sync_d[0] = req;
    for (int k = 1; k < SYNC_STAGES; k++) req_sync_d[k] = req_sync_q[k-1];
    res_ack_sync_d = {res_ack_sync_q[SYNC_STAGES-2:0], res_ack};
  end

  assign req_s     = req_sync_q[SYNC_STAGES-1];
  assign res_ack_s = res_ack_sync_q[SYNC_STAGES-1];
  assign eligible  = req_s & ~ack_q;

  // Search begins at ptr and wraps, so the requester just served is considered last.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found)          state_d = S_REQ;
      S_REQ:   if (res_ack_s)          state_d = S_HOLD;
      S_HOLD:  if (!req_s[grant_q])    state_d = S_RTZ;
      S_RTZ:   if (!res_ack_s)         state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  assign waiting = ((state_q == S_REQ) && !res_ack_s) || ((state_q == S_RTZ) && res_ack_s);

  always_comb begin
    ack_d     = ack_q;
    res_req_d = res_req_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d   = win_id;
          res_req_d = 1'b1;
          cnt_d     = '0;
        end
      end
      S_REQ: begin
        if (res_ack_s) ack_d[grant_q] = 1'b1;
      end
      S_HOLD: begin
        if (!req_s[grant_q]) begin
          res_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      S_RTZ: begin
        if (!res_ack_s) begin
          ack_d[grant_q] = 1'b0;
          ptr_d          = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
        end
      end
      default: ;
    endcase
    // Saturating count; with TMO == 0 it never leaves zero, which disables the flag.
    if (waiting && (cnt_q != TMO)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == TMO) err_d = 1'b1;
    end
  end

  assign ack         = ack_q;
  assign res_req     = res_req_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_hs_arbiter_4ph.sv
// tb/tb_hs_arbiter_4ph.sv - directed and randomized bench for hs_arbiter_4ph
// with behavioural requester/resource models and a timestamp-based grant predictor.
module tb_hs_arbiter_4ph;

  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] ack;
  logic         res_req;
  logic         res_ack = 1'b0;
  logic [1:0]   grant_id;
  logic         busy;
  logic         err_timeout;

  hs_arbiter_4ph #(
    .NUM_REQ(N), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .res_req(res_req),
    .res_ack(res_ack), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-pair 4-phase position: 0 idle, 1 req up, 2 acked, 3 req dropped.
  int       ph [N];
  int       rise_cyc [N];
  int       drop_cnt [N];
  int       done_cnt [N];
  int       ptr_m;
  int       grants [$];
  logic [N-1:0] prev_ack;
  logic     prev_res_req;
  bit       auto_raise, auto_drop, res_enable, res_rand;
  int       res_cnt;
  logic     res_target;
  int       jit;
  int       res_ack_rise_cyc, ack_rise_cyc;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ph[i] = 0; rise_cyc[i] = 0; drop_cnt[i] = 0; done_cnt[i] = 0;
    end
    ptr_m = 0;
    grants.delete();
    res_cnt = 0;
    res_target = 1'b0;
    auto_raise = 1'b0; auto_drop = 1'b1; res_enable = 1'b1; res_rand = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    res_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_res_req", res_req, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    prev_ack = '0;
    prev_res_req = 1'b0;
  endtask

  task automatic drive_req(input int i, input logic v, input bit allow_jit);
    if (allow_jit && jit < 4 && $urandom_range(0, 1) == 1) begin
      #1; jit++;
    end
    req[i] = v;
    if (v) begin
      ph[i] = 1;
      rise_cyc[i] = cyc;
    end else begin
      ph[i] = 3;
    end
  endtask

  // A request is seen by the arbiter SS+1 edges after it is raised; among those,
  // round-robin from ptr_m picks the first.
  function automatic int expected_winner();
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr_m + k) % N;
      if (req[idx] && ph[idx] == 1 && rise_cyc[idx] + SS + 1 <= cyc) return idx;
    end
    return -1;
  endfunction

  task automatic monitor();
    chk("ack_onehot", 32'($countones(ack) <= 1), 1);
    if (res_req && !prev_res_req) begin
      chk("grant_winner", grant_id, expected_winner());
      chk("res_req_rise_res_ack_lo", res_ack, 0);
      chk("grant_busy", busy, 1);
      grants.push_back(int'(grant_id));
    end
    if (!res_req && prev_res_req) begin
      chk("res_req_fall_res_ack_hi", res_ack, 1);
      chk("res_req_fall_ack_hi", ack[grant_id], 1);
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i] && !prev_ack[i]) begin
        chk("ack_rise_order", ph[i], 1);
        chk("ack_rise_res_ack", res_ack, 1);
        chk("ack_rise_gid", grant_id, i);
        ph[i] = 2;
        drop_cnt[i] = $urandom_range(0, 2);
        ack_rise_cyc = cyc;
      end
      if (!ack[i] && prev_ack[i]) begin
        chk("ack_fall_order", ph[i], 3);
        chk("ack_fall_res_ack", res_ack, 0);
        chk("ack_fall_idle", busy, 0);
        ph[i] = 0;
        ptr_m = (i + 1) % N;
        done_cnt[i]++;
      end
    end
    prev_ack = ack;
    prev_res_req = res_req;
  endtask

  task automatic env();
    jit = 0;
    for (int i = 0; i < N; i++) begin
      if (ph[i] == 2 && auto_drop) begin
        if (drop_cnt[i] == 0) drive_req(i, 1'b0, 1'b1);
        else drop_cnt[i]--;
      end else if (auto_raise && ph[i] == 0 && $urandom_range(0, 3) == 0) begin
        drive_req(i, 1'b1, 1'b1);
      end
    end
    if (res_cnt > 0) begin
      res_cnt--;
      if (res_cnt == 0) begin
        if (jit < 4 && $urandom_range(0, 1) == 1) begin
          #1; jit++;
        end
        res_ack = res_target;
        if (res_target) res_ack_rise_cyc = cyc;
      end
    end else if (res_enable && res_req !== res_ack) begin
      res_target = res_req;
      res_cnt = res_rand ? int'($urandom_range(1, 4)) : 3;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    env();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r, total;
    bit all_idle;
    do_reset();

    // Single requester: latency, grant id, full cycle.
    step();
    c0 = cyc;
    drive_req(2, 1'b1, 1'b0);
    step(); chk("t1_res_req_e0", res_req, 0);
    step(); chk("t1_res_req_e1", res_req, 0);
    step(); chk("t1_res_req_e2", res_req, 1);
    chk("t1_req_latency", cyc - c0, SS + 1);
    chk("t1_grant", grant_id, 2);
    for (int n = 0; n < 50 && !ack[2]; n++) step();
    chk("t1_ack_up", ack[2], 1);
    chk("t1_ack_latency", ack_rise_cyc - res_ack_rise_cyc, SS + 1);
    for (int n = 0; n < 100 && (busy || ph[2] != 0); n++) step();
    chk("t1_done", done_cnt[2], 1);
    chk("t1_busy", busy, 0);
    chk("t1_ack_zero", ack, 0);

    // ptr sits at 3: req 1 and 3 together -> 3 first, then wrap to 1.
    step();
    drive_req(1, 1'b1, 1'b0);
    drive_req(3, 1'b1, 1'b0);
    for (int n = 0; n < 200 && !(done_cnt[1] == 1 && done_cnt[3] == 1 && !busy); n++) step();
    chk("t3_count", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("t3_first", grants[1], 3);
      chk("t3_second", grants[2], 1);
    end

    // All four at once from reset: 0,1,2,3, then re-raised 0 and 2 -> 0 first.
    do_reset();
    step();
    for (int i = 0; i < N; i++) drive_req(i, 1'b1, 1'b0);
    for (int n = 0; n < 400 && !(done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3] == 4 && !busy); n++) step();
    chk("t2_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++) chk("t2_order", grants[k], k);
    for (int i = 0; i < N; i++) chk("t2_once", done_cnt[i], 1);
    step();
    drive_req(2, 1'b1, 1'b0);
    drive_req(0, 1'b1, 1'b0);
    for (int n = 0; n < 200 && !(done_cnt[0] == 2 && done_cnt[2] == 2 && !busy); n++) step();
    chk("t2_rerun_count", grants.size(), 6);
    if (grants.size() == 6) begin
      chk("t2_wrap_first", grants[4], 0);
      chk("t2_wrap_second", grants[5], 2);
    end

    // Timeout: resource silent, flag sets exactly TMO cycles after REQ entry.
    do_reset();
    res_enable = 1'b0;
    step();
    drive_req(0, 1'b1, 1'b0);
    for (int n = 0; n < 20 && !res_req; n++) step();
    chk("t4_res_req", res_req, 1);
    r = cyc;
    repeat (TMO - 1) step();
    chk("t4_err_before", err_timeout, 0);
    step();
    chk("t4_err_cycles", cyc - r, TMO);
    chk("t4_err_at", err_timeout, 1);
    chk("t4_in_req", {busy, res_req, ack[0]}, 3'b110);
    repeat (10) step();
    chk("t4_still_req", {busy, res_req, ack[0]}, 3'b110);
    res_enable = 1'b1;
    for (int n = 0; n < 100 && !(done_cnt[0] == 1 && !busy); n++) step();
    chk("t4_late_done", done_cnt[0], 1);
    chk("t4_err_sticky", err_timeout, 1);

    // Asynchronous reset with ack[1] high and res_req low.
    do_reset();
    auto_drop = 1'b0;
    step();
    drive_req(1, 1'b1, 1'b0);
    for (int n = 0; n < 50 && !ack[1]; n++) step();
    chk("t5_ack_up", ack[1], 1);
    res_enable = 1'b0;
    drive_req(1, 1'b0, 1'b0);
    for (int n = 0; n < 50 && res_req; n++) step();
    chk("t5_pre_state", {ack, res_req, busy}, 6'b0010_0_1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_ack", ack, 0);
    chk("t5_async_res_req", res_req, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_grant", grant_id, 0);
    do_reset();
    step();
    drive_req(1, 1'b1, 1'b0);
    for (int n = 0; n < 100 && !(done_cnt[1] == 1 && !busy); n++) step();
    chk("t5_regrant_done", done_cnt[1], 1);
    chk("t5_regrant_id", (grants.size() > 0) ? grants[0] : -1, 1);

    // Random jittered traffic.
    do_reset();
    auto_raise = 1'b1;
    res_rand = 1'b1;
    repeat (10000) step();
    auto_raise = 1'b0;
    all_idle = 1'b0;
    for (int n = 0; n < 300 && !all_idle; n++) begin
      step();
      all_idle = !busy;
      for (int i = 0; i < N; i++) if (ph[i] != 0) all_idle = 1'b0;
    end
    chk("rand_drained", all_idle, 1);
    total = 0;
    for (int i = 0; i < N; i++) begin
      total += done_cnt[i];
      chk("rand_served", 32'(done_cnt[i] > 0), 1);
    end
    chk("rand_grants_match", grants.size(), total);
    chk("rand_no_timeout", err_timeout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
